// File: rtl/sensor_conditioner.sv
// Synchronizes and debounces WIDTH sensor lines and reports accepted level changes on a valid/ready event channel.
// Optional macro SENSOR_EVENT_CNT_EN adds a saturating 16-bit count of accepted events (event_count).
module sensor_conditioner #(
   parameter int WIDTH           = 24,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] sensor_raw,
   output logic [31:0]      sensor_stable,
   output logic             change_valid,
   input  logic             change_ready,
   output logic [31:0]      change_mask,
   output logic             change_overrun
`ifdef SENSOR_EVENT_CNT_EN
   ,
   output logic [15:0]      event_count
`endif
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } ev_state_t;

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_bits;
   logic [WIDTH-1:0] stable_q;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [WIDTH-1:0] flip;

   ev_state_t        state_q, state_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic             ovr_q, ovr_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] seen_q, seen_d;
   logic             ovr_acc_q, ovr_acc_d;
   logic [WIDTH-1:0] merged;
   logic [WIDTH-1:0] merged_seen;
   logic             ovr_merged;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         sync_q[0] <= sensor_raw;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   assign sync_bits = sync_q[SYNC_STAGES-1];

   // A bit qualifies on the cycle its count reaches the last value while it still differs.
   always_comb begin
      flip = '0;
      for (int i = 0; i < WIDTH; i++) begin
         flip[i] = (sync_bits[i] != stable_q[i]) && (cnt_q[i] == CNT_LAST);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stable_q <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         stable_q <= stable_q ^ flip;
         for (int i = 0; i < WIDTH; i++) begin
            if ((sync_bits[i] == stable_q[i]) || flip[i]) begin
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Same-cycle flips are folded in so nothing is lost on the accept edge.
   assign merged      = acc_q ^ flip;
   assign merged_seen = seen_q | flip;
   assign ovr_merged  = ovr_acc_q | (|(flip & seen_q));

   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      ovr_d     = ovr_q;
      acc_d     = acc_q;
      seen_d    = seen_q;
      ovr_acc_d = ovr_acc_q;
      case (state_q)
         EMPTY: begin
            if (|flip) begin
               state_d = HOLD;
               mask_d  = flip;
               ovr_d   = 1'b0;
            end
         end
         HOLD: begin
            if (change_ready) begin
               acc_d     = '0;
               seen_d    = '0;
               ovr_acc_d = 1'b0;
               if (|merged_seen) begin
                  mask_d = merged_seen;
                  ovr_d  = ovr_merged;
               end else begin
                  state_d = EMPTY;
               end
            end else begin
               acc_d     = merged;
               seen_d    = merged_seen;
               ovr_acc_d = ovr_merged;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= EMPTY;
         mask_q    <= '0;
         ovr_q     <= 1'b0;
         acc_q     <= '0;
         seen_q    <= '0;
         ovr_acc_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         ovr_q     <= ovr_d;
         acc_q     <= acc_d;
         seen_q    <= seen_d;
         ovr_acc_q <= ovr_acc_d;
      end
   end

   assign change_valid   = (state_q == HOLD);
   assign change_overrun = ovr_q;
   assign change_mask    = 32'(mask_q);
   assign sensor_stable  = 32'(stable_q);

`ifdef SENSOR_EVENT_CNT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         event_count <= '0;
      end else if (change_valid && change_ready && (event_count != 16'hFFFF)) begin
         event_count <= event_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed scoreboard bench for sensor_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Honors SENSOR_EVENT_CNT_EN by also checking event_count.
module tb_sensor_conditioner;

   localparam int WIDTH = 24;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] sensor_raw = '0;
   logic        change_ready = 1'b0;
   logic [31:0] sensor_stable;
   logic        change_valid;
   logic [31:0] change_mask;
   logic        change_overrun;
`ifdef SENSOR_EVENT_CNT_EN
   logic [15:0] event_count;
`endif

   typedef struct packed {
      logic [31:0] mask;
      logic        ovr;
   } event_t;

   event_t exp_q[$];
   int     checks = 0;
   int     passes = 0;

   sensor_conditioner #(
      .WIDTH(WIDTH),
      .SYNC_STAGES(2),
      .DEBOUNCE_CYCLES(4),
      .CNT_W(3)
   ) dut (
      .clock(clock),
      .reset(reset),
      .sensor_raw(sensor_raw),
      .sensor_stable(sensor_stable),
      .change_valid(change_valid),
      .change_ready(change_ready),
      .change_mask(change_mask),
      .change_overrun(change_overrun)
`ifdef SENSOR_EVENT_CNT_EN
      ,
      .event_count(event_count)
`endif
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic applyStimulus(input logic [23:0] raw, input int settle);
      sensor_raw = raw;
      if (settle > 0) tick(settle);
   endtask

   task automatic pushEvent(input logic [31:0] mask, input logic ovr);
      event_t e;
      e.mask = mask;
      e.ovr  = ovr;
      exp_q.push_back(e);
   endtask

   task automatic waitValid(input string tag, input int budget);
      int n = 0;
      while (!change_valid && n < budget) begin
         tick(1);
         n++;
      end
      checkOutput(tag, {31'b0, change_valid}, 32'd1);
   endtask

   // Compare the presented event with the oldest expectation, then accept it for one edge.
   task automatic consumeEvent(input string tag);
      event_t e;
      checkOutput({tag, "_valid"}, {31'b0, change_valid}, 32'd1);
      if (exp_q.size() == 0) begin
         checks++;
         $error("[TB] FAIL %s_sb observed=empty expected=queued event", tag);
      end else begin
         e = exp_q.pop_front();
         checkOutput({tag, "_mask"}, change_mask, e.mask);
         checkOutput({tag, "_ovr"}, {31'b0, change_overrun}, {31'b0, e.ovr});
      end
      change_ready = 1'b1;
      tick(1);
      change_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      tick(3);
      checkOutput("rst_stable", sensor_stable, 32'h0);
      checkOutput("rst_valid", {31'b0, change_valid}, 32'h0);
      checkOutput("rst_mask", change_mask, 32'h0);
      checkOutput("rst_ovr", {31'b0, change_overrun}, 32'h0);
`ifdef SENSOR_EVENT_CNT_EN
      checkOutput("rst_count", {16'b0, event_count}, 32'h0);
`endif
      reset = 1'b0;
      tick(2);

      // Clean rising edge on bit 0: visible exactly 6 edges after the first sample.
      applyStimulus(24'h000001, 0);
      pushEvent(32'h1, 1'b0);
      tick(5);
      checkOutput("t1_early_stable", sensor_stable, 32'h0);
      checkOutput("t1_early_valid", {31'b0, change_valid}, 32'h0);
      tick(1);
      checkOutput("t1_stable", sensor_stable, 32'h1);
      consumeEvent("t1");
      checkOutput("t1_drained", {31'b0, change_valid}, 32'h0);

      // A 3-cycle glitch on bit 5 must be rejected.
      applyStimulus(24'h000021, 3);
      applyStimulus(24'h000001, 0);
      for (int c = 0; c < 10; c++) begin
         tick(1);
         checkOutput("t2_valid", {31'b0, change_valid}, 32'h0);
      end
      checkOutput("t2_stable", sensor_stable, 32'h1);

      // Second rise accumulates while the first event is held.
      applyStimulus(24'h000005, 0);
      pushEvent(32'h4, 1'b0);
      waitValid("t3_first", 10);
      applyStimulus(24'h00000D, 8);
      pushEvent(32'h8, 1'b0);
      checkOutput("t3_held", change_mask, 32'h4);
      checkOutput("t3_stable", sensor_stable, 32'hD);
      consumeEvent("t3a");
      consumeEvent("t3b");
      checkOutput("t3_drained", {31'b0, change_valid}, 32'h0);

      // Bit 7 rises and falls while held: reported once with overrun.
      applyStimulus(24'h00004D, 0);
      pushEvent(32'h40, 1'b0);
      waitValid("t4_first", 10);
      applyStimulus(24'h0000CD, 8);
      applyStimulus(24'h00004D, 8);
      pushEvent(32'h80, 1'b1);
      checkOutput("t4_stable", sensor_stable, 32'h4D);
      checkOutput("t4_held_mask", change_mask, 32'h40);
      checkOutput("t4_held_ovr", {31'b0, change_overrun}, 32'h0);
      consumeEvent("t4a");
      consumeEvent("t4b");
      checkOutput("t4_drained", {31'b0, change_valid}, 32'h0);

      // Bit 9 qualifies on the very edge that accepts the bit 10 event.
      applyStimulus(24'h00044D, 0);
      pushEvent(32'h400, 1'b0);
      waitValid("t5_first", 10);
      applyStimulus(24'h00064D, 0);
      pushEvent(32'h200, 1'b0);
      tick(5);
      checkOutput("t5_pre_stable", sensor_stable, 32'h44D);
      consumeEvent("t5a");
      checkOutput("t5_stable", sensor_stable, 32'h64D);
      consumeEvent("t5b");
      checkOutput("t5_drained", {31'b0, change_valid}, 32'h0);

      // Reset in the middle of bit 12's debounce, then full requalification.
      applyStimulus(24'h00164D, 0);
      tick(4);
      reset = 1'b1;
      #1;
      checkOutput("t6_rst_stable", sensor_stable, 32'h0);
      checkOutput("t6_rst_valid", {31'b0, change_valid}, 32'h0);
      checkOutput("t6_rst_mask", change_mask, 32'h0);
      checkOutput("t6_rst_ovr", {31'b0, change_overrun}, 32'h0);
      exp_q.delete();
      tick(2);
      reset = 1'b0;
      pushEvent(32'h164D, 1'b0);
      tick(5);
      checkOutput("t6_early_stable", sensor_stable, 32'h0);
      checkOutput("t6_early_valid", {31'b0, change_valid}, 32'h0);
      tick(1);
      checkOutput("t6_stable", sensor_stable, 32'h164D);
`ifdef SENSOR_EVENT_CNT_EN
      checkOutput("t6_count0", {16'b0, event_count}, 32'h0);
`endif
      consumeEvent("t6");
`ifdef SENSOR_EVENT_CNT_EN
      checkOutput("t6_count1", {16'b0, event_count}, 32'h1);
`endif
      checkOutput("t6_drained", {31'b0, change_valid}, 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
Front end for the 24 photo-sensor lines. It synchronizes and debounces each line, then drives the clean 32-bit sensor vector consumed by vga_controller and by the processor at address 0. It also reports which bits changed through a valid/ready event channel, so the processor can react to edges without polling. It sits between the board pins and the sensor_input net of the top level.

Parameters:
WIDTH, 24, number of sensor lines; output vectors are zero-extended to 32 bits.
SYNC_STAGES, 2, flip-flop synchronizer depth per line (minimum 2).
DEBOUNCE_CYCLES, 500000, consecutive cycles a new level must persist before it is accepted (10 ms at 50 MHz; minimum 1).
CNT_W, 19, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clock  in  1  system clock (CLOCK_50 domain)
reset  in  1  asynchronous, active-high reset
sensor_raw  in  WIDTH  raw asynchronous sensor pins
sensor_stable  out  32  debounced levels; bits [31:WIDTH] are 0
change_valid  out  1  a change event is presented
change_ready  in  1  consumer accepts the event
change_mask  out  32  bits that toggled since the previous accepted event; bits [31:WIDTH] are 0
change_overrun  out  1  at least one bit toggled twice or more inside the presented event

Behaviour:
- Reset (async assert, release synchronous to clock): synchronizer flops, counters, sensor_stable, accumulator, change_mask, change_overrun and change_valid all 0.
- Synchronizer: sensor_raw[i] passes through SYNC_STAGES flops to produce sync[i]. No combinational path from raw to any output.
- Debounce, per bit:
  - If sync[i] == stable[i], cnt[i] <= 0.
  - Otherwise cnt[i] increments each cycle.
  - On the edge where cnt[i] == DEBOUNCE_CYCLES-1 and the bit still differs, stable[i] toggles and cnt[i] <= 0. flip[i] is asserted that cycle (combinational, internal).
- Any glitch shorter than DEBOUNCE_CYCLES restarts the count; stable is unchanged.
- Latency: a clean raw edge appears on sensor_stable SYNC_STAGES+DEBOUNCE_CYCLES clock edges after the first sampling edge.
- Event channel, two states:
  - EMPTY (change_valid=0): when any flip occurs, load change_mask <= flip, change_overrun <= 0, and go to HOLD.
  - HOLD (change_valid=1): change_mask and change_overrun are held constant. New flips go into accumulator acc: acc <= acc ^ flip, and ovr_acc is set if flip & acc_seen != 0 (acc_seen = OR of all flips in acc).
  - Accept (change_valid & change_ready): merged = acc ^ flip (includes same-cycle flips).
    - If merged_seen != 0: change_mask <= merged_seen, change_overrun <= ovr_acc (including same cycle), stay in HOLD.
    - Otherwise go to EMPTY.
    - acc, acc_seen and ovr_acc clear on accept.
  - change_mask reports toggled bits as a set (acc_seen). Bits that toggled twice are still reported, with overrun set.
- Simultaneous flips on several bits in one cycle produce one event.
- change_ready while change_valid=0 is ignored.
- Reset mid-debounce discards partial counts. Lines held high through reset are re-qualified and generate a change event after the full latency.

Optional Feature:
Macro SENSOR_EVENT_CNT_EN.
- Defined:
  - Adds output event_count [15:0].
  - It increments by 1 on every accepted event (change_valid & change_ready) and saturates at 16'hFFFF.
  - It resets to 0.
- Not defined: the port is absent and no counter logic is generated.

Test Plan:
(All with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.)
1. Reset, hold sensor_raw=24'h000001 -> sensor_stable becomes 32'h00000001 exactly 6 edges after first sample; change_valid=1, change_mask=32'h1, change_overrun=0.
2. Pulse sensor_raw[5] high for 3 cycles, then low -> sensor_stable unchanged, change_valid stays 0.
3. change_ready=0; bit 2 rises, then bit 3 rises -> presented mask 32'h4 held. Pulse ready once -> next cycle mask 32'h8, valid=1. Pulse ready again -> valid=0.
4. Valid held with ready=0; bit 7 rises and fully falls (both qualified) -> after accept, next mask 32'h80, change_overrun=1.
5. A qualified flip on bit 9 lands in the same cycle as an accept -> no loss; the following event shows mask 32'h200.
6. Assert reset during a debounce with cnt=2 -> all outputs 0 immediately. After release with raw held, full 6-edge requalification occurs. With SENSOR_EVENT_CNT_EN defined, event_count reads 0 then 1 after accept.
